// File: rtl/prog_mem_if.sv
// Fetch and boot-loader signal bundle for prog_mem_loadable.
// The ld_csum signal exists only when PROG_MEM_CHECKSUM_EN is defined.
`timescale 1ns/1ps
interface prog_mem_if #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] Rom_addr_in;
  logic              Rom_rd_en;
  logic [DATA_W-1:0] Rom_data_out;
  logic              Rom_data_valid;
  logic              cpu_stall;
  logic              ld_start;
  logic [7:0]        ld_byte;
  logic              ld_byte_valid;
  logic              ld_byte_ready;
  logic              ld_done;
  logic              ld_err;
  logic [ADDR_W:0]   ld_word_count;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [15:0]       ld_csum;
`endif

  modport master (
    output Rom_addr_in, Rom_rd_en, ld_start, ld_byte, ld_byte_valid,
    input  Rom_data_out, Rom_data_valid, cpu_stall, ld_byte_ready,
           ld_done, ld_err, ld_word_count
`ifdef PROG_MEM_CHECKSUM_EN
    , input ld_csum
`endif
  );

  modport slave (
    input  Rom_addr_in, Rom_rd_en, ld_start, ld_byte, ld_byte_valid,
    output Rom_data_out, Rom_data_valid, cpu_stall, ld_byte_ready,
           ld_done, ld_err, ld_word_count
`ifdef PROG_MEM_CHECKSUM_EN
    , output ld_csum
`endif
  );
endinterface

// File: rtl/prog_mem_loadable.sv
// Program memory with registered read port and byte-serial boot loader.
// Optional macro PROG_MEM_CHECKSUM_EN adds the ld_csum running sum output.
`timescale 1ns/1ps
module prog_mem_loadable #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic      clk,
  input  logic      rst,
  prog_mem_if.slave bus
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                HI_W     = DATA_W - 8;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WR, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_word;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_wcount;
  logic              r_err;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              w_ready;
  logic              w_stall;
  logic              w_done;
  logic              w_accept;
  logic              w_start;
  logic              w_marker;
  logic              w_fmt_err;
  logic              w_last;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;

  assign w_accept   = bus.ld_byte_valid & w_ready;
  assign w_start    = bus.ld_start & (r_state == S_IDLE);
  assign w_marker   = (bus.ld_byte == 8'hFF);
  // High byte may only carry the top DATA_W-8 word bits.
  assign w_fmt_err  = |bus.ld_byte[7:HI_W];
  assign w_last     = (r_ptr == LAST_PTR);
  assign w_in_range = ({1'b0, bus.Rom_addr_in} < DEPTH_L);
  assign w_rd_idx   = bus.Rom_addr_in[IDX_W-1:0];
  assign w_wr_idx   = r_ptr[IDX_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_stall = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = 1'b0;
        if (bus.ld_start) w_next = S_LO;
      end
      S_LO: begin
        w_ready = 1'b1;
        if (bus.ld_byte_valid) w_next = S_HI;
      end
      S_HI: begin
        w_ready = 1'b1;
        if (bus.ld_byte_valid) begin
          if (w_marker)       w_next = S_DONE;
          else if (w_fmt_err) w_next = S_IDLE;
          else                w_next = S_WR;
        end
      end
      S_WR:    w_next = w_last ? S_DONE : S_LO;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Array has no reset so contents survive rst and map onto block RAM.
  always_ff @(posedge clk) begin
    if (r_state == S_WR) r_mem[w_wr_idx] <= r_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (bus.Rom_rd_en && !w_stall) begin
      r_rd_valid <= 1'b1;
      r_rd_data  <= w_in_range ? r_mem[w_rd_idx] : '0;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word   <= '0;
      r_ptr    <= '0;
      r_wcount <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_start) begin
        r_ptr    <= '0;
        r_wcount <= '0;
        r_err    <= 1'b0;
      end
      case (r_state)
        S_LO: if (w_accept) r_word[7:0] <= bus.ld_byte;
        S_HI: begin
          if (w_accept && !w_marker) begin
            if (w_fmt_err) r_err <= 1'b1;
            else           r_word[DATA_W-1:8] <= bus.ld_byte[HI_W-1:0];
          end
        end
        S_WR: begin
          r_ptr    <= r_ptr + 1'b1;
          r_wcount <= r_wcount + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef PROG_MEM_CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_csum <= '0;
    else if (w_start)           r_csum <= '0;
    else if (r_state == S_WR)   r_csum <= r_csum + {{(16-DATA_W){1'b0}}, r_word};
  end

  assign bus.ld_csum = r_csum;
`endif

  assign bus.Rom_data_out   = r_rd_data;
  assign bus.Rom_data_valid = r_rd_valid;
  assign bus.cpu_stall      = w_stall;
  assign bus.ld_byte_ready  = w_ready;
  assign bus.ld_done        = w_done;
  assign bus.ld_err         = r_err;
  assign bus.ld_word_count  = r_wcount;

endmodule
